fifo_to_lanes_distributor: RTL and testbench
============================================

FIFO_TO_LANES_DISTRIBUTOR -- requirements
Module: fifo_to_lanes_distributor

Parameters
REQ-001 The block SHALL have parameter LANES, default 4, meaning number of physical lanes driven (legal 1..4).
REQ-002 The block SHALL have parameter TMO_W, default 16, meaning width of the packet-to-packet timeout counter.

Interface
REQ-003 The block SHALL have port clk  in  1  clock; all logic rising-edge.
REQ-004 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port fifo_data  in  8*LANES  word; byte k is the data for lane k.
REQ-006 The block SHALL have port fifo_empty  in  1  high when the FIFO holds no word.
REQ-007 The block SHALL have port fifo_read  out  1  pop strobe; data is valid in the same cycle (show-ahead FIFO).
REQ-008 The block SHALL have port mode_lp_in  in  1  mode of the word at the FIFO head; 1 = LP, 0 = HS.
REQ-009 The block SHALL have port lanes_cfg  in  3  number of active lanes.
REQ-010 The block SHALL have port p2p_timeout  in  TMO_W  idle cycles enforced after each packet.
REQ-011 The block SHALL have port err_clr  in  1  clears the sticky error.
REQ-012 The block SHALL have port data_rqst  in  LANES  per-lane byte request.
REQ-013 The block SHALL have port start_rqst  out  LANES  per-lane packet start.
REQ-014 The block SHALL have port fin_rqst  out  LANES  per-lane packet finish.
REQ-015 The block SHALL have port inp_data  out  8*LANES  per-lane byte.
REQ-016 The block SHALL have port mode_lp  out  1  mode of the current word.
REQ-017 The block SHALL have port busy  out  1  high in any state other than IDLE, or while the timeout counter is nonzero.
REQ-018 The block SHALL have port err_desync  out  1  sticky lane-request mismatch flag.
REQ-019 The block SHALL have port pkt_cnt  out  16  count of completed packets.

Function
REQ-020 The block SHALL define fifo_avail = !fifo_empty & (tmo_cnt == 0).
REQ-021 The FSM SHALL have states IDLE, START, ACTIVE and FINISH, with reset state IDLE.
REQ-022 In IDLE, when fifo_avail: fifo_read=1, the word and mode_lp_in are registered into the output buffer, lanes_cfg is latched as act_mask, and the next state is START.
REQ-023 act_mask SHALL cover lanes 0..n-1, where n = lanes_cfg with 0 treated as 1 and values above LANES clamped to LANES.
REQ-024 act_mask SHALL be held constant until the FSM returns to IDLE; lanes_cfg changes mid-packet SHALL have no effect.
REQ-025 START SHALL assert start_rqst[k]=1 for every active lane for exactly one cycle, issue no fifo_read, and go to ACTIVE.
REQ-026 In ACTIVE, the all-request condition SHALL be that data_rqst is high on every active lane.
REQ-027 In ACTIVE with all-request and fifo_avail: fifo_read=1, the buffer and mode_lp update on the next edge, and the state stays ACTIVE.
REQ-028 In ACTIVE with all-request and fifo_empty: there SHALL be no read, and the next state is FINISH.
REQ-029 In ACTIVE without all-request: the block SHALL hold, with no read.
REQ-030 FINISH SHALL assert fin_rqst on active lanes for one cycle, load tmo_cnt with p2p_timeout, increment pkt_cnt modulo 2^16, and go to IDLE.
REQ-031 tmo_cnt SHALL decrement by 1 per cycle while nonzero and saturate at 0; with p2p_timeout=0, the next packet may start in the cycle after FINISH.
REQ-032 inp_data of an inactive lane SHALL be 0, and its start_rqst and fin_rqst SHALL be 0; byte k of fifo_data for an inactive lane SHALL be discarded.
REQ-033 In ACTIVE, if any data_rqst bit within act_mask differs from the others, err_desync SHALL be set the next cycle; data_rqst bits on inactive lanes SHALL be ignored.
REQ-034 err_desync SHALL be cleared by err_clr; when set and clear coincide, set SHALL win.
REQ-035 fifo_read SHALL never be asserted while fifo_empty=1.
REQ-036 At most one fifo_read SHALL occur per cycle.

Reset
REQ-037 On rst_n low, the block SHALL asynchronously enter IDLE with every output reset to 0: fifo_read, start_rqst, fin_rqst, inp_data, mode_lp, busy, err_desync, pkt_cnt; tmo_cnt and act_mask SHALL also be 0.
REQ-038 A reset mid-packet SHALL abort the packet with no fin_rqst issued, and the block SHALL restart cleanly from IDLE after release.

Verification
REQ-039 LANES=4, lanes_cfg=4, three words 0x44332211/0x88776655/0xCCBBAA99, data_rqst=4'hF constant -> start_rqst=4'hF for 1 cycle, lane0 bytes 11,55,99, then fin_rqst=4'hF once, pkt_cnt=1.
REQ-040 lanes_cfg=2, one word 0xDDCCBBAA -> inp_data lanes 0/1 = AA/BB, lanes 2/3 = 00, start/fin=4'b0011; lanes_cfg changed to 4 mid-packet -> no effect.
REQ-041 p2p_timeout=5, two packets queued -> the second fifo_read occurs no earlier than 6 cycles after the first fin_rqst; with p2p_timeout=0 -> it occurs 1 cycle after.
REQ-042 data_rqst=4'b0111 with lanes_cfg=4 in ACTIVE -> no read, err_desync=1 next cycle and held until err_clr; with lanes_cfg=3 the same pattern -> no error.
REQ-043 mode_lp_in toggles per word -> mode_lp follows the word registered, changing in the same cycle as inp_data.
REQ-044 rst_n low during ACTIVE -> all outputs 0 asynchronously, no fin_rqst; a new packet after release -> normal start, pkt_cnt counts from 0.

Source files
------------

// File: rtl/fifo_to_lanes_distributor.sv
//------------------------------------------------------------------------------
// Module   : fifo_to_lanes_distributor
// Brief    : Pops words from a show-ahead FIFO and fans their bytes out to up to
//            LANES lanes, framing each burst with per-lane start/finish strobes.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_to_lanes_distributor #(
  parameter int LANES = 4,
  parameter int TMO_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [8*LANES-1:0]   fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  input  logic                 mode_lp_in,
  input  logic [2:0]           lanes_cfg,
  input  logic [TMO_W-1:0]     p2p_timeout,
  input  logic                 err_clr,
  input  logic [LANES-1:0]     data_rqst,
  output logic [LANES-1:0]     start_rqst,
  output logic [LANES-1:0]     fin_rqst,
  output logic [8*LANES-1:0]   inp_data,
  output logic                 mode_lp,
  output logic                 busy,
  output logic                 err_desync,
  output logic [15:0]          pkt_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [2:0] MAX_LANES = 3'(LANES);

  state_t             state_q;
  logic [LANES-1:0]   act_mask_q;
  logic [LANES-1:0]   start_q;
  logic [LANES-1:0]   fin_q;
  logic [8*LANES-1:0] data_q;
  logic               mode_q;
  logic               err_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [15:0]        pkt_q;

  logic [2:0]         w_lanes_eff;
  logic [LANES-1:0]   w_cfg_mask;
  logic [LANES-1:0]   w_load_mask;
  logic [LANES-1:0]   w_req_act;
  logic [8*LANES-1:0] w_load_data;
  logic               w_fifo_avail;
  logic               w_in_active;
  logic               w_all_rqst;
  logic               w_desync;
  logic               w_pop;

  assign w_lanes_eff = (lanes_cfg == 3'd0)     ? 3'd1 :
                       (lanes_cfg > MAX_LANES) ? MAX_LANES : lanes_cfg;

  // A new packet takes its lane set from lanes_cfg; later words reuse the latched set.
  assign w_load_mask = (state_q == ST_IDLE) ? w_cfg_mask : act_mask_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_cfg_mask[k]          = (3'(k) < w_lanes_eff);
    assign w_load_data[8*k +: 8]  = fifo_data[8*k +: 8] & {8{w_load_mask[k]}};
  end

  assign w_fifo_avail = !fifo_empty && (tmo_q == '0);
  assign w_in_active  = (state_q == ST_ACTIVE);
  assign w_req_act    = data_rqst & act_mask_q;
  assign w_all_rqst   = (w_req_act == act_mask_q);
  assign w_desync     = w_in_active && (|w_req_act) && !w_all_rqst;

  // Show-ahead pop is combinational; gated by rst_n so it is quiet during reset.
  assign w_pop = rst_n && w_fifo_avail &&
                 ((state_q == ST_IDLE) || (w_in_active && w_all_rqst));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      act_mask_q <= '0;
      start_q    <= '0;
      fin_q      <= '0;
      data_q     <= '0;
      mode_q     <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
      pkt_q      <= '0;
    end else begin
      start_q <= '0;
      fin_q   <= '0;

      if (state_q == ST_FINISH) begin
        tmo_q <= p2p_timeout;
      end else if (tmo_q != '0) begin
        tmo_q <= tmo_q - TMO_W'(1);
      end

      if (w_desync) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end

      if (w_pop) begin
        data_q <= w_load_data;
        mode_q <= mode_lp_in;
      end

      case (state_q)
        ST_IDLE: begin
          if (w_fifo_avail) begin
            act_mask_q <= w_cfg_mask;
            start_q    <= w_cfg_mask;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (w_all_rqst && fifo_empty) begin
            fin_q   <= act_mask_q;
            state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          pkt_q   <= pkt_q + 16'd1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_read  = w_pop;
  assign start_rqst = start_q;
  assign fin_rqst   = fin_q;
  assign inp_data   = data_q;
  assign mode_lp    = mode_q;
  assign busy       = (state_q != ST_IDLE) || (tmo_q != '0);
  assign err_desync = err_q;
  assign pkt_cnt    = pkt_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_to_lanes_distributor.sv
//------------------------------------------------------------------------------
// Module   : tb_fifo_to_lanes_distributor
// Brief    : Directed and randomized bench with a queue-based FIFO and packet model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_to_lanes_distributor;

  localparam int LANES = 4;
  localparam int TMO_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_read;
  logic        mode_lp_in;
  logic [2:0]  lanes_cfg;
  logic [15:0] p2p_timeout;
  logic        err_clr;
  logic [3:0]  data_rqst;
  logic [3:0]  start_rqst;
  logic [3:0]  fin_rqst;
  logic [31:0] inp_data;
  logic        mode_lp;
  logic        busy;
  logic        err_desync;
  logic [15:0] pkt_cnt;

  always #5 clk = ~clk;

  fifo_to_lanes_distributor #(.LANES(LANES), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_read(fifo_read), .mode_lp_in(mode_lp_in), .lanes_cfg(lanes_cfg),
    .p2p_timeout(p2p_timeout), .err_clr(err_clr), .data_rqst(data_rqst),
    .start_rqst(start_rqst), .fin_rqst(fin_rqst), .inp_data(inp_data),
    .mode_lp(mode_lp), .busy(busy), .err_desync(err_desync), .pkt_cnt(pkt_cnt)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        m;
  } word_t;

  word_t fq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit last_read, last_fin;
  int last_cyc;
  int fc, rc;

  // Packet-level model: open packet, start/finish pulse pending, lane count, timeout.
  bit          m_open, m_start, m_fin, m_err, m_mode;
  int          m_n, m_tmo;
  logic [15:0] m_cnt;
  logic [31:0] m_buf;

  function automatic int clampn(logic [2:0] c);
    int ci = int'(c);
    if (ci == 0) return 1;
    if (ci > LANES) return LANES;
    return ci;
  endfunction

  function automatic logic [3:0] lmask(int n);
    return 4'((1 << n) - 1);
  endfunction

  function automatic logic [31:0] keep_bytes(logic [31:0] w, int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = w[8*k +: 8];
    return r;
  endfunction

  task automatic m_reset();
    m_open = 0; m_start = 0; m_fin = 0; m_err = 0; m_mode = 0;
    m_n = 0; m_tmo = 0; m_cnt = '0; m_buf = '0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    if (fq.size() == 0) begin
      fifo_empty = 1'b1; fifo_data = '0; mode_lp_in = 1'b0;
    end else begin
      fifo_empty = 1'b0; fifo_data = fq[0].d; mode_lp_in = fq[0].m;
    end
  endtask

  task automatic push(logic [31:0] d, logic m);
    word_t w;
    w.d = d;
    w.m = m;
    fq.push_back(w);
    drive_fifo();
  endtask

  // Called just after a rising edge: checks mid-cycle, advances model, crosses the edge.
  task automatic tick();
    logic [3:0] lm, req;
    bit active, allreq, avail, exp_read;
    #4;
    lm       = lmask(m_n);
    req      = data_rqst & lm;
    active   = m_open && !m_start && !m_fin;
    allreq   = (req == lm);
    avail    = (fq.size() > 0) && (m_tmo == 0);
    exp_read = rst_n && ((!m_open && avail) || (active && allreq && avail));
    chk("fifo_read",  32'(fifo_read),  32'(exp_read));
    chk("start_rqst", 32'(start_rqst), m_start ? 32'(lm) : 32'd0);
    chk("fin_rqst",   32'(fin_rqst),   m_fin ? 32'(lm) : 32'd0);
    chk("inp_data",   inp_data,        m_buf);
    chk("mode_lp",    32'(mode_lp),    32'(m_mode));
    chk("busy",       32'(busy),       32'(m_open || (m_tmo > 0)));
    chk("err_desync", 32'(err_desync), 32'(m_err));
    chk("pkt_cnt",    32'(pkt_cnt),    32'(m_cnt));
    last_read = fifo_read;
    last_fin  = (fin_rqst != 4'd0);
    last_cyc  = cyc;
    if (rst_n) begin
      if (active && (req != 4'd0) && !allreq) m_err = 1;
      else if (err_clr) m_err = 0;
      if (m_fin) begin
        m_cnt  = m_cnt + 16'd1;
        m_tmo  = int'(p2p_timeout);
        m_open = 0;
        m_fin  = 0;
      end else begin
        if (m_tmo > 0) m_tmo--;
        if (!m_open) begin
          if (avail) begin
            m_open  = 1;
            m_start = 1;
            m_n     = clampn(lanes_cfg);
            m_buf   = keep_bytes(fq[0].d, m_n);
            m_mode  = fq[0].m;
          end
        end else if (m_start) begin
          m_start = 0;
        end else if (allreq) begin
          if (avail) begin
            m_buf  = keep_bytes(fq[0].d, m_n);
            m_mode = fq[0].m;
          end else begin
            m_fin = 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (last_read && fq.size() > 0) void'(fq.pop_front());
    drive_fifo();
  endtask

  task automatic run_to_idle(string tag);
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      done = !m_open && (fq.size() == 0) && (m_tmo == 0);
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_fin(output int c);
    bit seen = 0;
    c = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (last_fin) begin seen = 1; c = last_cyc; end
    end
    chk("wait_fin", 32'(seen), 32'd1);
  endtask

  task automatic wait_read(output int c);
    bit seen = 0;
    c = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (last_read) begin seen = 1; c = last_cyc; end
    end
    chk("wait_read", 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; lanes_cfg = 3'd4; p2p_timeout = '0; err_clr = 1'b0; data_rqst = 4'hF;
    m_reset();
    drive_fifo();
    @(posedge clk);
    #1;
    tick();

    // Three-word packet on four lanes
    rst_n = 1'b1;
    push(32'h44332211, 1'b0); push(32'h88776655, 1'b0); push(32'hCCBBAA99, 1'b0);
    tick();
    chk("b2b_start", 32'(start_rqst), 32'hF);
    chk("b2b_w0", inp_data, 32'h44332211);
    tick();
    chk("b2b_start_once", 32'(start_rqst), 32'h0);
    tick();
    chk("b2b_lane0_w1", 32'(inp_data[7:0]), 32'h55);
    tick();
    chk("b2b_lane0_w2", 32'(inp_data[7:0]), 32'h99);
    tick();
    chk("b2b_fin", 32'(fin_rqst), 32'hF);
    tick();
    chk("b2b_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("b2b_fin_once", 32'(fin_rqst), 32'h0);

    // Two lanes; mid-packet lanes_cfg change must be ignored
    lanes_cfg = 3'd2;
    push(32'hDDCCBBAA, 1'b0);
    tick();
    chk("two_start", 32'(start_rqst), 32'h3);
    chk("two_data", inp_data, 32'h0000BBAA);
    lanes_cfg = 3'd4;
    tick();
    tick();
    chk("two_fin", 32'(fin_rqst), 32'h3);
    run_to_idle("two_idle");

    // Packet-to-packet timeout spacing
    p2p_timeout = 16'd5;
    push(32'h01020304, 1'b0);
    wait_fin(fc);
    push(32'h05060708, 1'b0);
    wait_read(rc);
    chk("p2p_gap_5", 32'(rc - fc), 32'd6);
    p2p_timeout = 16'd0;
    wait_fin(fc);
    push(32'h090A0B0C, 1'b0);
    wait_read(rc);
    chk("p2p_gap_0", 32'(rc - fc), 32'd1);
    run_to_idle("p2p_idle");

    // Lane request desync: error, set-over-clear priority, clear
    push(32'hA1A2A3A4, 1'b0); push(32'hB1B2B3B4, 1'b0);
    tick(); tick();
    data_rqst = 4'b0111;
    tick();
    chk("desync_set", 32'(err_desync), 32'd1);
    chk("desync_no_read", 32'(fifo_read), 32'd0);
    tick();
    err_clr = 1'b1;
    tick();
    chk("desync_set_wins", 32'(err_desync), 32'd1);
    data_rqst = 4'hF;
    tick();
    chk("desync_cleared", 32'(err_desync), 32'd0);
    err_clr = 1'b0;
    run_to_idle("desync_idle");
    lanes_cfg = 3'd3;
    push(32'hC1C2C3C4, 1'b0); push(32'hD1D2D3D4, 1'b0);
    tick(); tick();
    data_rqst = 4'b0111;
    tick(); tick(); tick();
    chk("desync_inactive_ignored", 32'(err_desync), 32'd0);
    data_rqst = 4'hF;
    run_to_idle("three_idle");

    // Mode follows each registered word
    lanes_cfg = 3'd4;
    push(32'h11111111, 1'b1); push(32'h22222222, 1'b0); push(32'h33333333, 1'b1);
    tick();
    chk("mode_w0", 32'(mode_lp), 32'd1);
    tick(); tick();
    chk("mode_w1", 32'(mode_lp), 32'd0);
    chk("mode_w1_data", inp_data, 32'h22222222);
    run_to_idle("mode_idle");

    // Asynchronous reset mid-packet
    push(32'h5A5A5A5A, 1'b1); push(32'h6B6B6B6B, 1'b0);
    tick(); tick();
    data_rqst = 4'h0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_read", 32'(fifo_read), 32'd0);
    chk("arst_start", 32'(start_rqst), 32'd0);
    chk("arst_fin", 32'(fin_rqst), 32'd0);
    chk("arst_data", inp_data, 32'd0);
    chk("arst_mode", 32'(mode_lp), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(err_desync), 32'd0);
    chk("arst_cnt", 32'(pkt_cnt), 32'd0);
    m_reset();
    tick();
    rst_n = 1'b1;
    data_rqst = 4'hF;
    run_to_idle("arst_idle");
    chk("arst_restart_cnt", 32'(pkt_cnt), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && fq.size() < 6) push($urandom, 1'($urandom_range(0, 1)));
      lanes_cfg = 3'($urandom_range(0, 7));
      data_rqst = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      err_clr   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) p2p_timeout = 16'($urandom_range(0, 4));
      tick();
    end
    data_rqst = 4'hF;
    err_clr = 1'b0;
    run_to_idle("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
